reg_write_arbiter: RTL
======================

# reg_write_arbiter

Arbitrates write access to a single shared WIDTH-bit state register among NREQ requesters, sequencing each grant through a small FSM with grant/ack handshakes, optional locked bursts, and a synchronous clear. It sits in front of the prioritised-update control registers in our control logic. It replaces ad hoc if/else-if write chains with one arbitrated write port, so exactly one writer updates the register per cycle.

## Interface
- NREQ, 4: number of requesters (2..8).
- WIDTH, 8: shared register width.
- MAX_BURST, 4: maximum consecutive writes per locked grant (1..16).

- CLK  input  1  clock, rising edge.
- RST  input  1  asynchronous, active-low reset.
- CLR  input  1  synchronous clear; highest priority after RST.
- REQ  input  NREQ  per-requester write request, level, held until ACK.
- LOCK  input  NREQ  per-requester burst lock, sampled while granted.
- DIN  input  NREQ*WIDTH  write data; requester i on bits [i*WIDTH +: WIDTH].
- GNT  output  NREQ  one-hot grant, registered.
- ACK  output  NREQ  one-cycle pulse per completed write, registered.
- WE  output  1  pulse coincident with each register update.
- Q  output  WIDTH  shared register value.
- BUSY  output  1  high when FSM is not IDLE.

## Operation
- FSM states: IDLE, WRITE.
- IDLE: if any REQ is high, select a winner g, set GNT = 1<<g, and go to WRITE. Otherwise hold.
- WRITE, each cycle:
  - Q <= DIN[g]; WE = 1; ACK[g] = 1; burst_cnt increments.
  - If LOCK[g] && REQ[g] && burst_cnt < MAX_BURST-1: stay in WRITE.
  - Else: clear GNT, reset burst_cnt, return to IDLE.
- Winner selection uses round-robin or fixed priority; see Configuration.
- REQ deasserted while granted: the write still completes, because the requester must hold REQ and DIN until ACK.
- CLR high on any edge:
  - Q <= 0; GNT, ACK, WE <= 0; state <= IDLE; burst_cnt <= 0.
  - The round-robin pointer is not modified.
  - An in-flight grant is aborted without ACK.
- RST low (asynchronous):
  - Q = 0, GNT = 0, ACK = 0, WE = 0, BUSY = 0, state = IDLE, burst_cnt = 0, pointer = 0.
- Reset mid-burst: all of the above apply immediately; no ACK is issued.
- burst_cnt width is clog2(MAX_BURST)+1 and never wraps.

## Timing
- REQ sampled high at edge k in IDLE: GNT valid after edge k. Q, WE and ACK update at edge k+1.
- Unlocked throughput: one write per 2 cycles. Back-to-back requests incur one IDLE cycle between grants.
- Locked burst: one write per cycle, at most MAX_BURST writes, then a mandatory IDLE cycle.
- ACK and WE are single-cycle pulses except during bursts, where they stay high for consecutive cycles.
- GNT stays stable for the entire grant.
- Simultaneous CLR and REQ: CLR wins and no grant is issued that cycle.

## Configuration
- REG_WRITE_ARB_RR_EN defined:
  - Round-robin arbitration. The pointer starts at 0.
  - After a grant to g ends, the pointer becomes (g+1) mod NREQ.
  - Search proceeds upward from the pointer with wrap-around.
- REG_WRITE_ARB_RR_EN undefined: fixed priority, lowest index wins. No pointer register exists.

## Test plan
- Reset: hold RST low with REQ=4'b1111 -> Q=0, GNT=0, ACK=0, BUSY=0. Release RST -> GNT=4'b0001 one cycle later.
- Single write: REQ[2]=1, DIN[2]=8'hA5 -> GNT=4'b0100 after 1 edge. Q=8'hA5, WE=1 and ACK=4'b0100 after 2 edges. BUSY=0 on the next cycle.
- Contention, RR_EN defined: REQ=4'b1111 held -> grants cycle 0,1,2,3,0, two cycles apart. Undefined: grants go to 0 only.
- Burst: REQ[1]=LOCK[1]=1, MAX_BURST=4, DIN[1] stepping 1,2,3,4,5 -> four consecutive WE/ACK pulses, Q ends at 4, then IDLE for one cycle before regrant.
- CLR mid-grant: CLR=1 on the cycle GNT=4'b1000 -> Q=0, no ACK, state IDLE. Pointer unchanged, verified by next grant order.
- Async reset mid-burst: RST low between edges during the third burst write -> outputs zero immediately; after release the pointer restarts at 0.

Source files
------------

// File: rtl/reg_write_arbiter.sv
// Arbitrated single write port in front of a shared WIDTH-bit state register.
// Define REG_WRITE_ARB_RR_EN for round-robin arbitration; fixed priority (lowest index) otherwise.
module reg_write_arbiter #(
    parameter int NREQ      = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  CLR,
    input  logic [NREQ-1:0]       REQ,
    input  logic [NREQ-1:0]       LOCK,
    input  logic [NREQ*WIDTH-1:0] DIN,
    output logic [NREQ-1:0]       GNT,
    output logic [NREQ-1:0]       ACK,
    output logic                  WE,
    output logic [WIDTH-1:0]      Q,
    output logic                  BUSY
);

    localparam int IDXW = $clog2(NREQ);
    localparam int BW   = $clog2(MAX_BURST) + 1;

    typedef enum logic {IDLE, WRITE} state_t;

    state_t           state_q, state_d;
    logic [IDXW-1:0]  sel_q, sel_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [NREQ-1:0]  ack_q, ack_d;
    logic             we_q, we_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [BW-1:0]    burst_q, burst_d;
    logic [IDXW-1:0]  win;
    logic [IDXW-1:0]  cand;
    logic             found;
    int               idx;

    logic [WIDTH-1:0] din_arr [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_din
        assign din_arr[gi] = DIN[gi*WIDTH +: WIDTH];
    end

`ifdef REG_WRITE_ARB_RR_EN
    logic [IDXW-1:0] ptr_q, ptr_d;
`endif

    // Winner search: upward from the pointer with wrap (RR) or from index 0.
    always_comb begin
        win   = '0;
        cand  = '0;
        found = 1'b0;
        idx   = 0;
        for (int off = 0; off < NREQ; off++) begin
`ifdef REG_WRITE_ARB_RR_EN
            idx = (int'(ptr_q) + off) % NREQ;
`else
            idx = off;
`endif
            cand = IDXW'(idx);
            if (!found && REQ[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        ack_d   = '0;
        we_d    = 1'b0;
        q_d     = q_q;
        burst_d = burst_q;
`ifdef REG_WRITE_ARB_RR_EN
        ptr_d   = ptr_q;
`endif
        if (CLR) begin
            // Abort any grant without ACK; the RR pointer is left alone.
            state_d = IDLE;
            gnt_d   = '0;
            q_d     = '0;
            burst_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found) begin
                        sel_d   = win;
                        gnt_d   = NREQ'(1) << win;
                        state_d = WRITE;
                    end
                end
                WRITE: begin
                    q_d   = din_arr[sel_q];
                    we_d  = 1'b1;
                    ack_d = gnt_q;
                    if (LOCK[sel_q] && REQ[sel_q] && burst_q < BW'(MAX_BURST - 1)) begin
                        burst_d = burst_q + 1'b1;
                    end else begin
                        burst_d = '0;
                        gnt_d   = '0;
                        state_d = IDLE;
`ifdef REG_WRITE_ARB_RR_EN
                        ptr_d   = (sel_q == IDXW'(NREQ - 1)) ? '0 : sel_q + 1'b1;
`endif
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            sel_q   <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            we_q    <= 1'b0;
            q_q     <= '0;
            burst_q <= '0;
`ifdef REG_WRITE_ARB_RR_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            we_q    <= we_d;
            q_q     <= q_d;
            burst_q <= burst_d;
`ifdef REG_WRITE_ARB_RR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign GNT  = gnt_q;
    assign ACK  = ack_q;
    assign WE   = we_q;
    assign Q    = q_q;
    assign BUSY = (state_q == WRITE);

endmodule
